// File: rtl/cic_interpolator.sv
// -----------------------------------------------------------------------------
// cic_interpolator
//
// Three-stage CIC interpolator with a differential delay of one. It upsamples
// a s16.15 stream by R = 2^F (F = 0..4) and sits between the transmit channel
// filter and the DAC-rate datapath. One input sample is requested every R
// enabled clocks, and one output sample is produced on every enabled clock.
// The output is normalised to unity DC gain (divide by R^2), rounded, and
// saturated back to s16.15.
//
// Datapath:
//   x_n -> 3 combs (low rate, advance only on in_req)
//       -> zero-stuffing register u (comb output or 0)
//       -> 3 integrators (high rate)
//       -> round, shift by 2F, saturate -> y_n
// Latency from a requested sample to its first output is 5 clocks for every R.
//
// Ports:
//   clk                   clock; all state changes on the rising edge
//   rst_n                 asynchronous active-low reset
//   EN                    clock enable; 0 freezes all state and drops in_req
//   bypass                1: y_n <= x_n every enabled cycle; filter state held
//   x_n                   signed input sample, consumed when in_req = 1
//   Interpolation_Factor  F, giving R = 2^F; codes 5..7 behave as 4
//   in_req                combinational request; x_n must be valid this cycle
//   y_n                   registered signed output sample
//
// Handshake: in_req is a pull strobe with no back-pressure. Upstream must
// present a valid x_n in every cycle where in_req = 1; the sample is taken on
// that rising edge. In bypass, a sample is taken on every enabled cycle.
// -----------------------------------------------------------------------------
module cic_interpolator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 26
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         EN,
  input  logic                         bypass,
  input  logic signed [DATA_WIDTH-1:0] x_n,
  input  logic        [2:0]            Interpolation_Factor,
  output logic                         in_req,
  output logic signed [DATA_WIDTH-1:0] y_n
);

  // Saturation limits, expressed at the width of the post-shift value.
  localparam logic signed [ACC_WIDTH:0] MAX_Y =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_Y =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        [2:0]            r_f;     // registered, clamped factor
  logic        [3:0]            r_ph;    // phase within one input period
  logic signed [ACC_WIDTH-1:0]  r_d1;    // comb delay registers
  logic signed [ACC_WIDTH-1:0]  r_d2;
  logic signed [ACC_WIDTH-1:0]  r_d3;
  logic signed [ACC_WIDTH-1:0]  r_u;     // zero-stuffed comb output
  logic signed [ACC_WIDTH-1:0]  r_i1;    // integrators
  logic signed [ACC_WIDTH-1:0]  r_i2;
  logic signed [ACC_WIDTH-1:0]  r_i3;
  logic signed [DATA_WIDTH-1:0] r_y;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic        [2:0]            w_f_clamped;
  logic                         w_f_change;
  logic                         w_run;
  logic                         w_ph_zero;
  logic        [3:0]            w_ph_max;

  // Factor codes above 4 behave as 4 (R = 16).
  assign w_f_clamped = (Interpolation_Factor > 3'd4) ? 3'd4 : Interpolation_Factor;
  assign w_f_change  = (w_f_clamped != r_f);
  assign w_run       = EN & ~bypass;
  assign w_ph_zero   = (r_ph == 4'd0);

  // Last phase value is R-1.
  always_comb begin
    w_ph_max = 4'd0;
    case (r_f)
      3'd1:    w_ph_max = 4'd1;
      3'd2:    w_ph_max = 4'd3;
      3'd3:    w_ph_max = 4'd7;
      3'd4:    w_ph_max = 4'd15;
      default: w_ph_max = 4'd0;
    endcase
  end

  // rst_n is included so that no request is seen while reset is held.
  assign in_req = rst_n & EN & (bypass | w_ph_zero);

  // ---------------------------------------------------------------------------
  // Comb section (combinational differences; delays are registered below)
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] w_x_ext;
  logic signed [ACC_WIDTH-1:0] w_c1;
  logic signed [ACC_WIDTH-1:0] w_c2;
  logic signed [ACC_WIDTH-1:0] w_c3;

  assign w_x_ext = {{(ACC_WIDTH-DATA_WIDTH){x_n[DATA_WIDTH-1]}}, x_n};
  assign w_c1    = w_x_ext - r_d1;
  assign w_c2    = w_c1 - r_d2;
  assign w_c3    = w_c2 - r_d3;

  // ---------------------------------------------------------------------------
  // Normalisation: (I3 + rnd) >>> 2F, then saturate.
  // One extra bit of headroom is kept so that adding rnd cannot wrap.
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH:0]    w_rnd;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic signed [ACC_WIDTH:0]    w_shifted;
  logic        [3:0]            w_shamt;
  logic signed [DATA_WIDTH-1:0] w_y_sat;

  // rnd = 2^(2F-1), i.e. half of one output LSB; zero when F = 0.
  always_comb begin
    w_rnd = '0;
    case (r_f)
      3'd1:    w_rnd[1] = 1'b1;
      3'd2:    w_rnd[3] = 1'b1;
      3'd3:    w_rnd[5] = 1'b1;
      3'd4:    w_rnd[7] = 1'b1;
      default: w_rnd    = '0;
    endcase
  end

  assign w_shamt   = {r_f, 1'b0};
  assign w_sum     = {r_i3[ACC_WIDTH-1], r_i3} + w_rnd;
  assign w_shifted = w_sum >>> w_shamt;

  always_comb begin
    w_y_sat = w_shifted[DATA_WIDTH-1:0];
    if (w_shifted > MAX_Y) begin
      w_y_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (w_shifted < MIN_Y) begin
      w_y_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f  <= 3'd0;
      r_ph <= 4'd0;
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
      r_u  <= '0;
      r_i1 <= '0;
      r_i2 <= '0;
      r_i3 <= '0;
      r_y  <= '0;
    end else if (EN && bypass) begin
      // The filter state is left untouched, so leaving bypass resumes it.
      r_y <= x_n;
    end else if (w_run && w_f_change) begin
      // A factor change restarts the filter. This takes precedence over a
      // sample requested in the same cycle, which is dropped. y_n keeps its
      // last value until the restarted pipeline produces the next sample.
      r_f  <= w_f_clamped;
      r_ph <= 4'd0;
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
      r_u  <= '0;
      r_i1 <= '0;
      r_i2 <= '0;
      r_i3 <= '0;
    end else if (w_run) begin
      r_ph <= (r_ph == w_ph_max) ? 4'd0 : r_ph + 4'd1;

      // The combs advance once per input sample; R-1 zeros are stuffed
      // between successive comb outputs.
      if (w_ph_zero) begin
        r_d1 <= w_x_ext;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        r_u  <= w_c3;
      end else begin
        r_u  <= '0;
      end

      // Modular accumulation: wrap-around cancels across the comb/integrator
      // pair, so no overflow handling is needed here.
      r_i1 <= r_i1 + r_u;
      r_i2 <= r_i2 + r_i1;
      r_i3 <= r_i3 + r_i2;
      r_y  <= w_y_sat;
    end
  end

  assign y_n = r_y;

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Transmit-side counterpart of the receive-path CIC decimator: a 3-stage CIC interpolator (differential delay 1) that upsamples a s16.15 sample stream by R = 2^Interpolation_Factor (1, 2, 4, 8, 16). It sits between the transmit channel filter and the DAC-rate datapath. It requests one input sample every R clocks and emits one output sample every clock. Output is gain-normalized to unity DC gain, rounded and saturated back to s16.15.

## Interface
- DATA_WIDTH, 16, input/output sample width (s16.15)
- ACC_WIDTH, 26, internal comb/integrator width (two's complement, modular)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- EN  input  1  clock enable; 0 freezes all state
- bypass  input  1  1: filter bypassed, y_n = registered x_n
- x_n  input  DATA_WIDTH  signed input sample, consumed on cycles where in_req=1
- Interpolation_Factor  input  3  R = 2^F; values 5..7 treated as 4
- in_req  output  1  sample request strobe; upstream must present x_n in the same cycle
- y_n  output  DATA_WIDTH  signed output sample, new value every enabled cycle

## Operation
- Phase counter ph (0..R-1): increments each EN cycle, wraps at R-1. in_req = EN & (ph==0) & rst_n (combinational); in bypass, in_req = EN.
- Comb section (low rate, updates only when in_req=1): x_n sign-extended to ACC_WIDTH, 3 cascaded c_k = in_k - in_k_delayed; delay registers update only on in_req cycles.
- Upsampler register u: u <= comb output when in_req=1, else 0 (zero-stuffing, R-1 zeros per sample).
- Integrators I1, I2, I3 (high rate): I1 += u, I2 += I1, I3 += I2 every EN cycle; wrap-around is intended and harmless.
- Normalization: DC gain is R^2; output = sat16((I3 + rnd) >>> 2F), rnd = 2^(2F-1) for F>0, 0 for F=0; arithmetic shift; saturate to [0x8000, 0x7FFF].
- Factor change: Interpolation_Factor is registered; on any change, ph, comb delays, u and integrators clear to 0 on the next enabled edge; y_n keeps its value until the next computed sample.
- EN=0: ph, comb, integrators, y_n hold; in_req=0.
- bypass=1: y_n <= x_n each EN cycle; filter state holds untouched; leaving bypass resumes filter from held state.

## Timing
- Reset (rst_n low, async): y_n=0, ph=0, u=0, all comb/integrator registers=0, factor register=0; in_req=0 while rst_n low.
- After reset release with EN=1: in_req=1 on the first cycle.
- Filter latency: sample accepted at in_req edge t -> u at t+1 -> I1 t+2 -> I2 t+3 -> I3 t+4 -> y_n at t+5 (5 cycles, all R).
- Bypass latency: 1 cycle.
- Reset asserted mid-stream: immediate clear, no partial output; stream restarts cleanly.
- Simultaneous factor change and in_req: the clear wins; that sample is dropped.

## Test plan
- Reset mid-run with nonzero y_n -> y_n=0 and in_req=0 asynchronously; after release in_req=1 first cycle, y_n=0 until a nonzero sample propagates.
- F=0, impulse x_n=0x4000 on one in_req, else 0 -> in_req high every cycle; y_n=0x4000 exactly 5 cycles later, 0 on all other cycles.
- F=2, impulse x_n=0x1000 -> in_req every 4th cycle; y_n from t+5 = 0x100,0x300,0x600,0xA00,0xC00,0xC00,0xA00,0x600,0x300,0x100, then 0.
- F=4, DC x_n=0x7FFF then DC 0x8000 -> y_n settles to exactly 0x7FFF then 0x8000, no wrap or glitch beyond range.
- bypass=1, x_n ramp 0,1,2,... -> y_n=ramp delayed 1 cycle, in_req every cycle; EN=0 for 3 cycles -> y_n and in_req frozen/0.
- F changed 1->3 mid-stream with DC 0x2000 -> state cleared next edge, in_req spacing becomes 8, y_n resettles to 0x2000 within 5+3*8 cycles.
